sample_ring_reader: RTL

SAMPLE_RING_READER -- requirements
Module: sample_ring_reader

---
 rtl/sample_ring_pkg.sv | 30 +++
 rtl/sample_skid_fifo.sv | 56 +++++
 rtl/sample_ring_reader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sample_ring_pkg.sv
// Shared definitions for the sample ring reader.
//   state_e      : reader FSM states
//   DefBaseAddr  : default RAM address of ring slot 0
//   DefDepth     : default number of ring slots
//   FifoDepth    : entries in the return-data skid FIFO
//   ring_advance : step a slot index forward, wrapping at the ring depth
package sample_ring_pkg;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    localparam logic [11:0] DefBaseAddr = 12'hC7F;
    localparam int unsigned DefDepth    = 641;
    localparam int unsigned FifoDepth   = 2;

    // Slot arithmetic is one bit wider than head_ptr so slot + step never overflows.
    localparam int unsigned IdxW    = 11;
    localparam int unsigned OutIdxW = 10;
    localparam int unsigned DataW   = 32;
    // FIFO entry layout: {data, index, last}
    localparam int unsigned BeatW   = DataW + OutIdxW + 1;

    function automatic logic [IdxW-1:0] ring_advance(input logic [IdxW-1:0] slot,
                                                     input logic [IdxW-1:0] step,
                                                     input logic [IdxW-1:0] depth);
        logic [IdxW-1:0] sum;
        sum = slot + step;
        return (sum >= depth) ? sum - depth : sum;
    endfunction

endpackage

// File: rtl/sample_skid_fifo.sv
// Two-entry FIFO buffering RAM return data ahead of the output stream.
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    : write side handshake, in_data entry
//   out_valid/out_ready  : read side handshake, out_data head entry
//   count                : current occupancy (0..2)
module sample_skid_fifo
    import sample_ring_pkg::*;
#(
    parameter int unsigned Width = BeatW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data,
    output logic [1:0]       count
);

    logic [Width-1:0] mem_q [FifoDepth];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/sample_ring_reader.sv
// Reads one frame of samples out of a circular RAM buffer, oldest first, and
// streams them out with their position in the frame.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   start, head_ptr     : frame request and oldest-sample slot (latched on accept)
//   busy                : frame in progress
//   mem_grant           : RAM port B free this cycle
//   mem_rd, mem_addr    : read request and address; mem_rdata returns one cycle later
//   out_valid/out_ready : output stream handshake
//   out_data, out_index, out_last : sample, frame position, final-sample marker
// Build option: define SAMPLE_RING_READER_DECIM_EN to read every second slot,
// giving ceil(DEPTH/2) samples per frame; otherwise all DEPTH slots are read.
module sample_ring_reader
    import sample_ring_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 12,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(DefBaseAddr),
    parameter int unsigned        DEPTH     = DefDepth
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        head_ptr,
    output logic              busy,
    input  logic              mem_grant,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [9:0]        out_index,
    output logic              out_last
);

`ifdef SAMPLE_RING_READER_DECIM_EN
    localparam int unsigned Step     = 2;
    localparam int unsigned NumReads = (DEPTH + 1) / 2;
`else
    localparam int unsigned Step     = 1;
    localparam int unsigned NumReads = DEPTH;
`endif

    localparam logic [IdxW-1:0]    DepthI   = IdxW'(DEPTH);
    localparam logic [IdxW-1:0]    StepI    = IdxW'(Step);
    localparam logic [IdxW-1:0]    LastRead = IdxW'(NumReads - 1);
    localparam logic [OutIdxW-1:0] LastBeat = OutIdxW'(NumReads - 1);

    state_e              state_q;
    logic                busy_q;
    logic [IdxW-1:0]     slot_q;
    logic [IdxW-1:0]     rd_cnt_q;
    logic [OutIdxW-1:0]  push_idx_q;
    logic                inflight_q;
    logic [ADDR_W-1:0]   addr_q;

    logic [IdxW-1:0]     head_slot;
    logic [IdxW-1:0]     slot_nxt;
    logic                rd_granted;
    logic                beat;
    logic                room;
    logic                fifo_in_ready;
    logic [1:0]          fifo_count;
    logic [BeatW-1:0]    fifo_in;
    logic [BeatW-1:0]    fifo_out;

    // Out-of-range head pointers restart the frame at slot 0.
    assign head_slot = ({1'b0, head_ptr} >= DepthI) ? '0 : {1'b0, head_ptr};
    assign slot_nxt  = ring_advance(slot_q, StepI, DepthI);
    assign beat      = out_valid && out_ready;

    // A read granted now lands in the FIFO next cycle; it needs a free entry after
    // this cycle's push (the read in flight) and pop (the beat leaving).
    assign room       = ({1'b0, fifo_count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, beat});
    assign mem_rd     = (state_q == StIssue) && room && fifo_in_ready;
    assign rd_granted = mem_rd && mem_grant;
    assign mem_addr   = addr_q;
    assign busy       = busy_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            slot_q     <= '0;
            rd_cnt_q   <= '0;
            push_idx_q <= '0;
            inflight_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            inflight_q <= rd_granted;
            if (inflight_q) begin
                push_idx_q <= push_idx_q + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StIssue;
                        busy_q     <= 1'b1;
                        slot_q     <= head_slot;
                        rd_cnt_q   <= '0;
                        push_idx_q <= '0;
                        addr_q     <= BASE_ADDR + ADDR_W'(head_slot);
                    end
                end
                StIssue: begin
                    // An ungranted read keeps its address and is retried.
                    if (rd_granted) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                        slot_q   <= slot_nxt;
                        addr_q   <= BASE_ADDR + ADDR_W'(slot_nxt);
                        if (rd_cnt_q == LastRead) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // The final beat is the last FIFO entry, so its acceptance empties it.
                    if (beat && out_last) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_in = {mem_rdata, push_idx_q, (push_idx_q == LastBeat)};

    sample_skid_fifo #(
        .Width (BeatW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (inflight_q),
        .in_ready  (fifo_in_ready),
        .in_data   (fifo_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

    assign out_data  = fifo_out[BeatW-1 -: DataW];
    assign out_index = fifo_out[1 +: OutIdxW];
    assign out_last  = fifo_out[0];

endmodule
